// File: rtl/axis_output_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// axis_output_arbiter_pkg
// Shared types and constants for the router output-channel arbiter:
//   - axis_data_t / axis_mosi_t : AXI-Stream forward path (TVALID + payload)
//   - axis_miso_t               : AXI-Stream backward path (TREADY)
//   - ROUTING_HEADER            : TID value tagging the first flit of a packet
//   - arb_state_t               : arbiter FSM states
// -----------------------------------------------------------------------------
package axis_output_arbiter_pkg;

    localparam int AXIS_DATA_WIDTH = 40;
    localparam int AXIS_ID_WIDTH   = 2;

    // TID carried by the routing header flit; the arbiter itself never looks at it.
    localparam logic [AXIS_ID_WIDTH-1:0] ROUTING_HEADER = 2'd1;

    typedef struct packed {
        logic [AXIS_ID_WIDTH-1:0]   TID;
        logic                       TLAST;
        logic [AXIS_DATA_WIDTH-1:0] TDATA;
    } axis_data_t;

    typedef struct packed {
        logic       TVALID;
        axis_data_t data;
    } axis_mosi_t;

    typedef struct packed {
        logic TREADY;
    } axis_miso_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/axis_output_arbiter_rr_priority_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Combinational round-robin search: returns the first set bit of i_req when
// scanning i_ptr, i_ptr+1, ... wrapping from N-1 back to 0.
// Ports:
//   i_req   [N-1:0]  request vector
//   i_ptr   [W-1:0]  starting index of the search (must be < N)
//   o_found          at least one request is set
//   o_idx   [W-1:0]  index of the winner (0 when o_found is low)
// -----------------------------------------------------------------------------
module rr_priority_picker
    import axis_output_arbiter_pkg::*;
#(
    parameter int N = 5,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic         o_found,
    output logic [W-1:0] o_idx
);

    // One extra bit so ptr + offset cannot overflow before the wrap subtract.
    localparam int SW = W + 1;

    logic [SW-1:0] w_cand;

    // Scan offsets 0..N-1 from the pointer; the first hit wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = {1'b0, i_ptr} + SW'(k);
            // Explicit wrap instead of a modulo, so non-power-of-2 N stays cheap.
            if (w_cand >= SW'(N)) begin
                w_cand = w_cand - SW'(N);
            end else begin
                w_cand = w_cand;
            end
            if (!o_found && i_req[w_cand[W-1:0]]) begin
                o_found = 1'b1;
                o_idx   = w_cand[W-1:0];
            end else begin
                o_found = o_found;
            end
        end
    end

endmodule

// File: rtl/axis_output_arbiter.sv
// -----------------------------------------------------------------------------
// axis_output_arbiter
// Packet-level round-robin arbiter for one router output channel. One input
// owns the output from its first flit through the TLAST handshake; priority
// then rotates to the index after the owner. Arbitration costs one IDLE
// bubble per packet; while LOCKED the owner is passed through combinationally.
// Ports:
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   in_mosi_i[N]   requester streams (TVALID is the request)
//   in_miso_o[N]   TREADY back to requesters (only the owner ever sees it)
//   out_mosi_o     arbitrated stream to the output link
//   out_miso_i     downstream TREADY
//   grant_valid_o  high while an input owns the output
//   grant_idx_o    owner index, meaningful when grant_valid_o is high
// -----------------------------------------------------------------------------
module axis_output_arbiter
    import axis_output_arbiter_pkg::*;
#(
    parameter int CHANNEL_NUMBER       = 5,
    parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  axis_mosi_t                      in_mosi_i [CHANNEL_NUMBER],
    output axis_miso_t                      in_miso_o [CHANNEL_NUMBER],
    output axis_mosi_t                      out_mosi_o,
    input  axis_miso_t                      out_miso_i,
    output logic                            grant_valid_o,
    output logic [CHANNEL_NUMBER_WIDTH-1:0] grant_idx_o
);

    arb_state_t                      r_state;
    arb_state_t                      w_next_state;
    logic [CHANNEL_NUMBER_WIDTH-1:0] r_rr_ptr;
    logic [CHANNEL_NUMBER_WIDTH-1:0] r_grant_idx;
    logic [CHANNEL_NUMBER-1:0]       w_req;
    logic                            w_found;
    logic [CHANNEL_NUMBER_WIDTH-1:0] w_pick_idx;
    logic                            w_release;

    // Request vector is simply each input's TVALID.
    always_comb begin
        w_req = '0;
        for (int i = 0; i < CHANNEL_NUMBER; i++) begin
            w_req[i] = in_mosi_i[i].TVALID;
        end
    end

    rr_priority_picker #(
        .N (CHANNEL_NUMBER),
        .W (CHANNEL_NUMBER_WIDTH)
    ) u_picker (
        .i_req   (w_req),
        .i_ptr   (r_rr_ptr),
        .o_found (w_found),
        .o_idx   (w_pick_idx)
    );

    // Next-state decode and output muxing; outputs depend only on state and owner.
    always_comb begin
        w_next_state = r_state;
        w_release    = 1'b0;
        out_mosi_o   = '0;
        for (int i = 0; i < CHANNEL_NUMBER; i++) begin
            in_miso_o[i] = '0;
        end
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_next_state = LOCKED;
                end else begin
                    w_next_state = IDLE;
                end
            end
            LOCKED: begin
                out_mosi_o             = in_mosi_i[r_grant_idx];
                in_miso_o[r_grant_idx] = out_miso_i;
                // Ownership ends only on the accepted last flit; a TVALID gap never preempts.
                w_release = in_mosi_i[r_grant_idx].TVALID
                          & in_mosi_i[r_grant_idx].data.TLAST
                          & out_miso_i.TREADY;
                if (w_release) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = LOCKED;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State, owner and round-robin pointer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && w_found) begin
                r_grant_idx <= w_pick_idx;
            end else begin
                r_grant_idx <= r_grant_idx;
            end
            // Priority moves to the input just after the releasing owner.
            if (w_release) begin
                if (r_grant_idx == CHANNEL_NUMBER_WIDTH'(CHANNEL_NUMBER - 1)) begin
                    r_rr_ptr <= '0;
                end else begin
                    r_rr_ptr <= r_grant_idx + CHANNEL_NUMBER_WIDTH'(1);
                end
            end else begin
                r_rr_ptr <= r_rr_ptr;
            end
        end
    end

    assign grant_valid_o = (r_state == LOCKED);
    assign grant_idx_o   = r_grant_idx;

endmodule
